// File: rtl/io_ports_n.sv
// rtl/io_ports_n.sv - parametrised CPU I/O port bank with handshaked input/output channels
// Optional interrupt request logic is enabled by defining IO_IRQ_EN.
module io_ports_n #(
  parameter int WIDTH  = 8,
  parameter int NPORTS = 4,
  parameter int SELW   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SELW-1:0]          port_sel,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [NPORTS*WIDTH-1:0]  in_data,
  input  logic [NPORTS-1:0]        in_valid,
  output logic [NPORTS-1:0]        in_ready,
  output logic [NPORTS-1:0]        in_avail,
  output logic [NPORTS-1:0]        in_ovr,
  output logic [NPORTS*WIDTH-1:0]  out_data,
  output logic [NPORTS-1:0]        out_valid,
  input  logic [NPORTS-1:0]        out_ack,
  input  logic [NPORTS-1:0]        irq_mask,
  output logic                     irq
);

  logic [WIDTH-1:0]  hold [NPORTS];
  logic [NPORTS-1:0] full;
  logic [NPORTS-1:0] full_next;
  logic [NPORTS-1:0] ovr;

  for (genvar k = 0; k < NPORTS; k++) begin : g_ch
    localparam logic [SELW-1:0] K = SELW'(k);

    logic             rd_hit;
    logic             wr_hit;
    logic             capture;
    logic             full_q;
    logic             ovr_q;
    logic             oval_q;
    logic [WIDTH-1:0] hold_q;
    logic [WIDTH-1:0] odata_q;

    assign rd_hit  = rd_en && (port_sel == K);
    assign wr_hit  = wr_en && (port_sel == K);
    assign capture = in_valid[k] && !full_q;

    // A capture into an empty register wins over a read of that same empty register.
    assign full_next[k] = capture || (full_q && !rd_hit);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hold_q  <= '0;
        full_q  <= 1'b0;
        ovr_q   <= 1'b0;
        odata_q <= '0;
        oval_q  <= 1'b0;
      end else begin
        if (capture) begin
          hold_q <= in_data[k*WIDTH +: WIDTH];
        end
        full_q <= full_next[k];
        if (rd_hit) begin
          ovr_q <= 1'b0;
        end else if (in_valid[k] && full_q) begin
          ovr_q <= 1'b1;
        end
        if (wr_hit) begin
          odata_q <= wr_data;
          oval_q  <= 1'b1;
        end else if (out_ack[k]) begin
          oval_q  <= 1'b0;
        end
      end
    end

    assign hold[k]                    = hold_q;
    assign full[k]                    = full_q;
    assign ovr[k]                     = ovr_q;
    assign out_valid[k]               = oval_q;
    assign out_data[k*WIDTH +: WIDTH] = odata_q;
  end

  assign in_ready = ~full;
  assign in_avail = full;
  assign in_ovr   = ovr;

  // Selects beyond NPORTS match no channel and so read back as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (port_sel == SELW'(i)) begin
        rd_data = hold[i];
      end
    end
  end

`ifdef IO_IRQ_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= |(full_next & irq_mask);
    end
  end
`else
  logic unused_irq_mask;
  assign unused_irq_mask = ^irq_mask;
  assign irq             = 1'b0;
`endif

endmodule
